// File: rtl/sol32_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sol32_memory_arbiter
// Description : Shares one external memory bus between the sol32 instruction
//               fetch port and the load/store data port. Latches the granted
//               request, runs one registered bus transaction, returns data
//               and a completion pulse, and alternates grants on contention.
//               A watchdog aborts accesses that are never acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module sol32_memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        FetchRequest,
    input  logic [31:0] FetchAddress,
    output logic [31:0] FetchData,
    output logic        FetchReady,
    input  logic        DataReadEnable,
    input  logic        DataWriteEnable,
    input  logic [1:0]  DataWidth,
    input  logic [31:0] DataAddress,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    output logic        ReadComplete,
    output logic        WriteComplete,
    output logic        BusRequest,
    output logic        BusWrite,
    output logic [1:0]  BusWidth,
    output logic [31:0] BusAddress,
    output logic [31:0] BusWriteData,
    input  logic [31:0] BusReadData,
    input  logic        BusAck,
    output logic        Fault
);

    // A zero timeout disables the watchdog; keep the counter at least one bit.
    localparam int              c_CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              c_WDOG_EN = (TIMEOUT_CYCLES > 0);
    // Abort fires on the unacknowledged cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [1:0] c_WIDTH_WORD = 2'b10;

    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;
    logic               r_lastGrantData;   // 0 = fetch was granted last, 1 = data
    logic [c_CNT_W-1:0] r_count;

    logic w_dataPend;
    logic w_grantData;
    logic w_grantFetch;
    logic w_timeout;

    // Grant decision, watchdog expiry and next-state selection.
    always_comb begin
        w_stateNext  = r_state;
        w_dataPend   = DataReadEnable | DataWriteEnable;
        // On a tie the port that did not win last time gets the bus.
        w_grantData  = w_dataPend && (!FetchRequest || !r_lastGrantData);
        w_grantFetch = FetchRequest && !w_grantData;
        // A same-cycle acknowledge takes precedence over the abort.
        w_timeout    = c_WDOG_EN && (r_count == c_LIMIT) && !BusAck;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grantData) begin
                    w_stateNext = c_ST_DATA;
                end else if (w_grantFetch) begin
                    w_stateNext = c_ST_FETCH;
                end
            end
            c_ST_FETCH, c_ST_DATA: begin
                if (BusAck || w_timeout) begin
                    w_stateNext = c_ST_DONE;
                end
            end
            default: w_stateNext = c_ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Registered bus fields, returned data, completion pulses and watchdog count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            BusRequest      <= 1'b0;
            BusWrite        <= 1'b0;
            BusWidth        <= 2'b00;
            BusAddress      <= 32'h0;
            BusWriteData    <= 32'h0;
            FetchData       <= 32'h0;
            DataIn          <= 32'h0;
            FetchReady      <= 1'b0;
            ReadComplete    <= 1'b0;
            WriteComplete   <= 1'b0;
            Fault           <= 1'b0;
            r_lastGrantData <= 1'b0;
            r_count         <= '0;
        end else begin
            FetchReady    <= 1'b0;
            ReadComplete  <= 1'b0;
            WriteComplete <= 1'b0;
            Fault         <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grantData) begin
                        // Read and write together is a store; the read is dropped.
                        BusRequest      <= 1'b1;
                        BusWrite        <= DataWriteEnable;
                        BusWidth        <= DataWidth;
                        BusAddress      <= DataAddress;
                        BusWriteData    <= DataWriteEnable ? DataOut : 32'h0;
                        r_lastGrantData <= 1'b1;
                        r_count         <= '0;
                    end else if (w_grantFetch) begin
                        BusRequest      <= 1'b1;
                        BusWrite        <= 1'b0;
                        BusWidth        <= c_WIDTH_WORD;
                        BusAddress      <= FetchAddress;
                        BusWriteData    <= 32'h0;
                        r_lastGrantData <= 1'b0;
                        r_count         <= '0;
                    end
                end
                c_ST_FETCH, c_ST_DATA: begin
                    if (BusAck || w_timeout) begin
                        BusRequest <= 1'b0;
                        Fault      <= !BusAck;
                        if (r_state == c_ST_FETCH) begin
                            FetchReady <= 1'b1;
                            FetchData  <= BusAck ? BusReadData : 32'h0;
                        end else if (BusWrite) begin
                            WriteComplete <= 1'b1;
                        end else begin
                            ReadComplete <= 1'b1;
                            DataIn       <= BusAck ? BusReadData : 32'h0;
                        end
                    end else if (c_WDOG_EN) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sol32_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sol32_memory_arbiter
// Description : Directed self-checking bench for sol32_memory_arbiter with a
//               four-cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sol32_memory_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        FetchRequest = 1'b0;
    logic [31:0] FetchAddress = 32'h0;
    logic [31:0] FetchData;
    logic        FetchReady;
    logic        DataReadEnable = 1'b0;
    logic        DataWriteEnable = 1'b0;
    logic [1:0]  DataWidth = 2'b00;
    logic [31:0] DataAddress = 32'h0;
    logic [31:0] DataOut = 32'h0;
    logic [31:0] DataIn;
    logic        ReadComplete;
    logic        WriteComplete;
    logic        BusRequest;
    logic        BusWrite;
    logic [1:0]  BusWidth;
    logic [31:0] BusAddress;
    logic [31:0] BusWriteData;
    logic [31:0] BusReadData = 32'h0;
    logic        BusAck = 1'b0;
    logic        Fault;

    int checks = 0;
    int errors = 0;

    sol32_memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .FetchRequest(FetchRequest), .FetchAddress(FetchAddress),
        .FetchData(FetchData), .FetchReady(FetchReady),
        .DataReadEnable(DataReadEnable), .DataWriteEnable(DataWriteEnable),
        .DataWidth(DataWidth), .DataAddress(DataAddress), .DataOut(DataOut),
        .DataIn(DataIn), .ReadComplete(ReadComplete), .WriteComplete(WriteComplete),
        .BusRequest(BusRequest), .BusWrite(BusWrite), .BusWidth(BusWidth),
        .BusAddress(BusAddress), .BusWriteData(BusWriteData),
        .BusReadData(BusReadData), .BusAck(BusAck), .Fault(Fault)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        FetchRequest = 1'b0; DataReadEnable = 1'b0; DataWriteEnable = 1'b0;
        BusAck = 1'b0; BusReadData = 32'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        checks++;
        if ({BusRequest, BusWrite, BusWidth, FetchReady, ReadComplete, WriteComplete, Fault} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {BusRequest, BusWrite, BusWidth, FetchReady, ReadComplete, WriteComplete, Fault});
        end
        checks++;
        if ({BusAddress, BusWriteData, FetchData, DataIn} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero",
                     BusAddress, BusWriteData, FetchData, DataIn);
        end
    endtask

    // Both ports held from reset: grants must go data, fetch, data, fetch.
    task automatic test_alternate();
        logic [31:0] expAddr;
        clear_inputs();
        Reset = 1'b1;
        tick();
        FetchRequest = 1'b1; FetchAddress = 32'h1000;
        DataReadEnable = 1'b1; DataWidth = 2'b10; DataAddress = 32'h2000;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();  // IDLE samples both requests
            expAddr = (i % 2 == 0) ? 32'h2000 : 32'h1000;
            checks++;
            if (BusRequest !== 1'b1 || BusAddress !== expAddr) begin
                errors++;
                $display("FAIL alt_grant%0d: req=%b addr=%h expected req=1 addr=%h",
                         i, BusRequest, BusAddress, expAddr);
            end
            BusAck = 1'b1; BusReadData = 32'hA000_0000 + i;
            tick();
            BusAck = 1'b0;
            checks++;
            if (i % 2 == 0) begin
                if (ReadComplete !== 1'b1 || FetchReady !== 1'b0 || DataIn !== 32'hA000_0000 + i) begin
                    errors++;
                    $display("FAIL alt_done%0d: rc=%b fr=%b DataIn=%h expected rc=1 fr=0 DataIn=%h",
                             i, ReadComplete, FetchReady, DataIn, 32'hA000_0000 + i);
                end
            end else begin
                if (FetchReady !== 1'b1 || ReadComplete !== 1'b0 || FetchData !== 32'hA000_0000 + i) begin
                    errors++;
                    $display("FAIL alt_done%0d: fr=%b rc=%b FetchData=%h expected fr=1 rc=0 FetchData=%h",
                             i, FetchReady, ReadComplete, FetchData, 32'hA000_0000 + i);
                end
            end
            tick();  // DONE -> IDLE, requests ignored
            checks++;
            if (BusRequest !== 1'b0) begin
                errors++;
                $display("FAIL alt_done_idle%0d: BusRequest=%b expected 0", i, BusRequest);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_fetch();
        apply_reset();
        FetchRequest = 1'b1; FetchAddress = 32'h100;
        tick();
        checks++;
        if ({BusRequest, BusWrite, BusWidth} !== 4'b1010 || BusAddress !== 32'h100) begin
            errors++;
            $display("FAIL fetch_bus: req/wr/width=%b addr=%h expected 1010 addr=00000100",
                     {BusRequest, BusWrite, BusWidth}, BusAddress);
        end
        tick(); tick();
        checks++;
        if (BusRequest !== 1'b1 || FetchReady !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: req=%b ready=%b expected req=1 ready=0", BusRequest, FetchReady);
        end
        BusAck = 1'b1; BusReadData = 32'hDEADBEEF;
        tick();
        BusAck = 1'b0; BusReadData = 32'h0; FetchRequest = 1'b0;
        checks++;
        if (FetchReady !== 1'b1 || FetchData !== 32'hDEADBEEF || BusRequest !== 1'b0 || Fault !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: ready=%b data=%h req=%b fault=%b expected 1 deadbeef 0 0",
                     FetchReady, FetchData, BusRequest, Fault);
        end
        tick();
        checks++;
        if (FetchReady !== 1'b0 || FetchData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_after: ready=%b data=%h expected 0 deadbeef", FetchReady, FetchData);
        end
        tick();
    endtask

    task automatic test_store();
        apply_reset();
        DataWriteEnable = 1'b1; DataWidth = 2'b00; DataAddress = 32'h203; DataOut = 32'hAB;
        tick();
        checks++;
        if ({BusRequest, BusWrite, BusWidth} !== 4'b1100 || BusAddress !== 32'h203 || BusWriteData !== 32'hAB) begin
            errors++;
            $display("FAIL store_bus: req/wr/width=%b addr=%h wdata=%h expected 1100 203 ab",
                     {BusRequest, BusWrite, BusWidth}, BusAddress, BusWriteData);
        end
        BusAck = 1'b1;
        tick();
        BusAck = 1'b0; DataWriteEnable = 1'b0;
        checks++;
        if (WriteComplete !== 1'b1 || ReadComplete !== 1'b0 || BusRequest !== 1'b0) begin
            errors++;
            $display("FAIL store_done: wc=%b rc=%b req=%b expected 1 0 0", WriteComplete, ReadComplete, BusRequest);
        end
        tick(); tick();
        // Read and write together behave as a store; width 11 passes through.
        DataReadEnable = 1'b1; DataWriteEnable = 1'b1; DataWidth = 2'b11;
        DataAddress = 32'h400; DataOut = 32'h1234_5678;
        tick();
        checks++;
        if ({BusRequest, BusWrite, BusWidth} !== 4'b1111 || BusWriteData !== 32'h1234_5678) begin
            errors++;
            $display("FAIL store_rw: req/wr/width=%b wdata=%h expected 1111 12345678",
                     {BusRequest, BusWrite, BusWidth}, BusWriteData);
        end
        BusAck = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (WriteComplete !== 1'b1 || ReadComplete !== 1'b0) begin
            errors++;
            $display("FAIL store_rw_done: wc=%b rc=%b expected 1 0", WriteComplete, ReadComplete);
        end
        tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        // A successful load first, so the zero on abort is visible.
        DataReadEnable = 1'b1; DataWidth = 2'b10; DataAddress = 32'h300;
        tick();
        BusAck = 1'b1; BusReadData = 32'h55;
        tick();
        BusAck = 1'b0; DataReadEnable = 1'b0;
        checks++;
        if (ReadComplete !== 1'b1 || DataIn !== 32'h55) begin
            errors++;
            $display("FAIL to_preload: rc=%b DataIn=%h expected 1 00000055", ReadComplete, DataIn);
        end
        tick(); tick();
        DataReadEnable = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (BusRequest !== 1'b1 || ReadComplete !== 1'b0) begin
                errors++;
                $display("FAIL to_wait%0d: req=%b rc=%b expected 1 0", c, BusRequest, ReadComplete);
            end
        end
        tick();
        DataReadEnable = 1'b0;
        checks++;
        if (BusRequest !== 1'b0 || ReadComplete !== 1'b1 || Fault !== 1'b1 || DataIn !== 32'h0) begin
            errors++;
            $display("FAIL to_abort: req=%b rc=%b fault=%b DataIn=%h expected 0 1 1 0",
                     BusRequest, ReadComplete, Fault, DataIn);
        end
        tick();
        checks++;
        if (Fault !== 1'b0 || ReadComplete !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: fault=%b rc=%b expected 0 0", Fault, ReadComplete);
        end
        tick();
        // Acknowledge on the same cycle the watchdog would expire.
        DataReadEnable = 1'b1;
        tick();
        tick(); tick(); tick();
        BusAck = 1'b1; BusReadData = 32'h77;
        tick();
        clear_inputs();
        checks++;
        if (ReadComplete !== 1'b1 || Fault !== 1'b0 || DataIn !== 32'h77) begin
            errors++;
            $display("FAIL to_late_ack: rc=%b fault=%b DataIn=%h expected 1 0 00000077",
                     ReadComplete, Fault, DataIn);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        DataReadEnable = 1'b1; DataWidth = 2'b10; DataAddress = 32'h500;
        tick();
        checks++;
        if (BusRequest !== 1'b1) begin
            errors++;
            $display("FAIL mid_start: req=%b expected 1", BusRequest);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (BusRequest !== 1'b0 || ReadComplete !== 1'b0 || Fault !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: req=%b rc=%b fault=%b expected 0 0 0", BusRequest, ReadComplete, Fault);
        end
        FetchRequest = 1'b1; FetchAddress = 32'h600;
        Reset = 1'b0;
        tick();
        checks++;
        if (BusRequest !== 1'b1 || BusAddress !== 32'h500) begin
            errors++;
            $display("FAIL mid_tie: req=%b addr=%h expected 1 00000500", BusRequest, BusAddress);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_fetch();
        test_store();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
